// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 7-segment display path: segment patterns,
// capture codes and the capture FSM state type.
package sevenseg_pkg;

  // Active-low segment patterns, bit ordering gfedcba (bit0 = a).
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Codes stored in a slot for a dark digit and for an unrecognised pattern.
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ERR_CODE   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HOLD
  } cap_state_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational decode of an active-low segment pattern back to BCD.
// Blank decodes to BLANK_CODE without error; anything unrecognised
// decodes to ERR_CODE with err set.
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] segs_n,
  output logic [3:0] code,
  output logic       err
);

  // Pattern lookup against the shared segment table.
  always_comb begin
    code = ERR_CODE;
    err  = 1'b1;
    case (segs_n)
      SEG_0:     begin code = 4'd0;       err = 1'b0; end
      SEG_1:     begin code = 4'd1;       err = 1'b0; end
      SEG_2:     begin code = 4'd2;       err = 1'b0; end
      SEG_3:     begin code = 4'd3;       err = 1'b0; end
      SEG_4:     begin code = 4'd4;       err = 1'b0; end
      SEG_5:     begin code = 4'd5;       err = 1'b0; end
      SEG_6:     begin code = 4'd6;       err = 1'b0; end
      SEG_7:     begin code = 4'd7;       err = 1'b0; end
      SEG_8:     begin code = 4'd8;       err = 1'b0; end
      SEG_9:     begin code = 4'd9;       err = 1'b0; end
      SEG_BLANK: begin code = BLANK_CODE; err = 1'b0; end
      default:   begin code = ERR_CODE;   err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Receive side of the multiplexed 7-segment bus. Synchronises the pins,
// waits for a stable dwell, decodes the strobed digit into its slot and
// signals when every slot has been refreshed since the last frame pulse.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              segs_n,
  input  logic                    dp_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   seg_err,
  output logic                    an_err,
  output logic                    frame_done
);

  localparam int W  = 8 + NUM_DIGITS;
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [W-1:0]          sync1, sync2;
  logic                  changing;
  logic [CW-1:0]         cnt;
  logic [NUM_DIGITS-1:0] v_an;

  logic                  an_ok;
  logic [IW-1:0]         an_idx;

  cap_state_e            state;
  logic [IW-1:0]         cap_idx;
  logic [6:0]            cap_segs;
  logic                  cap_dp_n;

  logic [3:0]            dec_code;
  logic                  dec_err;

  logic [NUM_DIGITS-1:0] seen;

  // Two-flop synchroniser; reset to all ones so the bus looks dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {an_n, dp_n, segs_n};
      sync2 <= sync1;
    end
  end

  assign v_an = sync2[W-1:8];

  // v is about to change whenever the two stages disagree; using this
  // look-ahead keeps the counter aligned with v itself, so cnt == 0 on the
  // first cycle a new value is visible at the second stage.
  assign changing = (sync1 != sync2);

  // Dwell counter: restarts on every change of v, saturates at the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (changing) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // One-hot-low check on the synchronised anodes and index of the low line.
  always_comb begin
    logic one_low;
    logic multi_low;
    one_low   = 1'b0;
    multi_low = 1'b0;
    an_idx    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!v_an[i]) begin
        if (one_low) multi_low = 1'b1;
        one_low = 1'b1;
        an_idx  = IW'(i);
      end
    end
    an_ok = one_low && !multi_low;
  end

  // Capture FSM. The dwell's pattern is latched on entry to CAPTURE so the
  // write uses it even if v moves on during the CAPTURE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      an_err   <= 1'b0;
      cap_idx  <= '0;
      cap_segs <= SEG_BLANK;
      cap_dp_n <= 1'b1;
    end else begin
      an_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cnt == CNT_MAX) begin
            if (an_ok) begin
              state    <= ST_CAPTURE;
              cap_idx  <= an_idx;
              cap_segs <= sync2[6:0];
              cap_dp_n <= sync2[7];
            end else begin
              state  <= ST_HOLD;
              an_err <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          state <= changing ? ST_IDLE : ST_HOLD;
        end
        ST_HOLD: begin
          if (changing) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  seg_decode u_decode (
    .segs_n (cap_segs),
    .code   (dec_code),
    .err    (dec_err)
  );

  // Slot registers: written only in CAPTURE, never cleared by frame completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits  <= '1;
      dp      <= '0;
      seg_err <= '0;
    end else if (state == ST_CAPTURE) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (cap_idx == IW'(i)) begin
          digits[4*i +: 4] <= dec_code;
          dp[i]            <= ~cap_dp_n;
          seg_err[i]       <= dec_err;
        end
      end
    end
  end

  // Frame tracking: pulse once the seen mask fills, then start a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (seen == '1);
      if (seen == '1) begin
        seen <= '0;
      end else if (state == ST_CAPTURE) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (cap_idx == IW'(i)) seen[i] <= 1'b1;
        end
      end
    end
  end

endmodule
